// File: rtl/dual_port_mem_pkg.sv
// Shared types and default sizing for the dual-port memory block.
package dual_port_mem_pkg;
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  localparam int ADDR_WIDTH_DEF = 8;
  localparam int DATA_WIDTH_DEF = 8;
endpackage

// File: rtl/dual_port_mem_if.sv
// Request/response bundle for both memory ports; master drives requests, slave answers.
interface dual_port_mem_if
  import dual_port_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
);
  logic                  valid_a;
  logic                  op_a;
  logic [ADDR_WIDTH-1:0] addr_a;
  logic [DATA_WIDTH-1:0] wr_data_a;
  logic                  ready_a;
  logic [DATA_WIDTH-1:0] rd_data_a;

  logic                  valid_b;
  logic                  op_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [DATA_WIDTH-1:0] wr_data_b;
  logic                  ready_b;
  logic [DATA_WIDTH-1:0] rd_data_b;

  modport master (
    output valid_a, op_a, addr_a, wr_data_a,
    output valid_b, op_b, addr_b, wr_data_b,
    input  ready_a, rd_data_a, ready_b, rd_data_b
  );

  modport slave (
    input  valid_a, op_a, addr_a, wr_data_a,
    input  valid_b, op_b, addr_b, wr_data_b,
    output ready_a, rd_data_a, ready_b, rd_data_b
  );
endinterface

// File: rtl/dual_port_mem_port.sv
// One request port: qualifies the handshake, emits the array write strobe and
// owns the registered read data, which holds until the next accepted read.
module dual_port_mem_port
  import dual_port_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  valid,
  input  op_e                   op,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  ready_en,
  input  logic                  stall,
  input  logic [DATA_WIDTH-1:0] rd_word,
  output logic                  ready,
  output logic                  we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [DATA_WIDTH-1:0] rd_data
);
  logic                  accept;
  logic [DATA_WIDTH-1:0] rd_data_q, rd_data_d;

  assign ready     = ready_en && !stall;
  assign accept    = valid && ready;
  assign we        = accept && (op == OP_WRITE);
  assign mem_addr  = addr;
  assign mem_wdata = wr_data;
  assign rd_data   = rd_data_q;

  // rd_word is the pre-edge array content, so a read never sees a same-edge write
  always_comb begin
    rd_data_d = rd_data_q;
    if (accept && (op == OP_READ)) rd_data_d = rd_word;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) rd_data_q <= '0;
    else       rd_data_q <= rd_data_d;
  end
endmodule

// File: rtl/dual_port_mem.sv
// True dual-port memory: shared array, post-reset ready enable, and the
// A-over-B stall for same-address accesses involving a write.
module dual_port_mem
  import dual_port_mem_pkg::*;
#(
  parameter int ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic            clk,
  input  logic            rstn,
  dual_port_mem_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                             ready_en_q, ready_en_d;
  logic                             conflict;

  logic                  we_a, we_b;
  logic [ADDR_WIDTH-1:0] maddr_a, maddr_b;
  logic [DATA_WIDTH-1:0] wdata_a, wdata_b;

  assign conflict = bus.valid_a && bus.valid_b && (bus.addr_a == bus.addr_b)
                 && (bus.op_a || bus.op_b);

  dual_port_mem_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_port_a (
    .clk      (clk),
    .rstn     (rstn),
    .valid    (bus.valid_a),
    .op       (op_e'(bus.op_a)),
    .addr     (bus.addr_a),
    .wr_data  (bus.wr_data_a),
    .ready_en (ready_en_q),
    .stall    (1'b0),
    .rd_word  (mem_q[bus.addr_a]),
    .ready    (bus.ready_a),
    .we       (we_a),
    .mem_addr (maddr_a),
    .mem_wdata(wdata_a),
    .rd_data  (bus.rd_data_a)
  );

  dual_port_mem_port #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_port_b (
    .clk      (clk),
    .rstn     (rstn),
    .valid    (bus.valid_b),
    .op       (op_e'(bus.op_b)),
    .addr     (bus.addr_b),
    .wr_data  (bus.wr_data_b),
    .ready_en (ready_en_q),
    .stall    (conflict),
    .rd_word  (mem_q[bus.addr_b]),
    .ready    (bus.ready_b),
    .we       (we_b),
    .mem_addr (maddr_b),
    .mem_wdata(wdata_b),
    .rd_data  (bus.rd_data_b)
  );

  // B applied last; the stall keeps both strobes from hitting one word anyway
  always_comb begin
    mem_d = mem_q;
    if (we_a) mem_d[maddr_a] = wdata_a;
    if (we_b) mem_d[maddr_b] = wdata_b;
  end

  assign ready_en_d = 1'b1;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      mem_q      <= '0;
      ready_en_q <= 1'b0;
    end else begin
      mem_q      <= mem_d;
      ready_en_q <= ready_en_d;
    end
  end
endmodule

// File: tb/tb_dual_port_mem.sv
// Directed bench for dual_port_mem: vector table for single-cycle cases plus
// hand sequences for reset, fill/readback, read hold and mid-stream reset.
module tb_dual_port_mem;
  import dual_port_mem_pkg::*;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  dual_port_mem_if bus ();

  dual_port_mem u_dut (
    .clk (clk),
    .rstn(rstn),
    .bus (bus)
  );

  typedef struct {
    logic       va;
    logic       opa;
    logic [7:0] aa;
    logic [7:0] da;
    logic       vb;
    logic       opb;
    logic [7:0] ab;
    logic [7:0] db;
    logic       rdy_a;
    logic       rdy_b;
    logic [7:0] rd_a;
    logic [7:0] rd_b;
  } vec_t;

  vec_t tbl[15];

  function automatic vec_t mk(logic va, logic opa, logic [7:0] aa, logic [7:0] da,
                              logic vb, logic opb, logic [7:0] ab, logic [7:0] db,
                              logic rdy_a, logic rdy_b, logic [7:0] rd_a, logic [7:0] rd_b);
    vec_t v;
    v.va = va; v.opa = opa; v.aa = aa; v.da = da;
    v.vb = vb; v.opb = opb; v.ab = ab; v.db = db;
    v.rdy_a = rdy_a; v.rdy_b = rdy_b; v.rd_a = rd_a; v.rd_b = rd_b;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input logic v, input logic op, input logic [7:0] a, input logic [7:0] d);
    bus.valid_a = v; bus.op_a = op; bus.addr_a = a; bus.wr_data_a = d;
  endtask

  task automatic set_b(input logic v, input logic op, input logic [7:0] a, input logic [7:0] d);
    bus.valid_b = v; bus.op_b = op; bus.addr_b = a; bus.wr_data_b = d;
  endtask

  task automatic idle();
    set_a(1'b0, 1'b0, 8'h00, 8'h00);
    set_b(1'b0, 1'b0, 8'h00, 8'h00);
  endtask

  initial begin
    // after fill: mem[i] = i ^ A5, rd_a = 00 (A never read), rd_b = FF^A5 = 5A
    tbl[0]  = mk(1, 1, 8'h20, 8'h77, 0, 0, 8'h00, 8'h00, 1, 1, 8'h00, 8'h5A);
    tbl[1]  = mk(1, 1, 8'h10, 8'h3C, 1, 0, 8'h20, 8'h00, 1, 1, 8'h00, 8'h77);
    tbl[2]  = mk(1, 0, 8'h10, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 8'h3C, 8'h77);
    tbl[3]  = mk(1, 1, 8'h40, 8'h11, 0, 0, 8'h00, 8'h00, 1, 1, 8'h3C, 8'h77);
    tbl[4]  = mk(1, 1, 8'h40, 8'h99, 1, 0, 8'h40, 8'h00, 1, 0, 8'h3C, 8'h77);
    tbl[5]  = mk(0, 0, 8'h00, 8'h00, 1, 0, 8'h40, 8'h00, 1, 1, 8'h3C, 8'h99);
    tbl[6]  = mk(1, 1, 8'h41, 8'h12, 1, 1, 8'h41, 8'h34, 1, 0, 8'h3C, 8'h99);
    tbl[7]  = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h41, 8'h34, 1, 1, 8'h3C, 8'h99);
    tbl[8]  = mk(1, 0, 8'h41, 8'h00, 1, 0, 8'h41, 8'h00, 1, 1, 8'h34, 8'h34);
    tbl[9]  = mk(1, 0, 8'h30, 8'h00, 1, 0, 8'h31, 8'h00, 1, 1, 8'h95, 8'h94);
    tbl[10] = mk(1, 0, 8'h60, 8'h00, 1, 1, 8'h60, 8'hEE, 1, 0, 8'hC5, 8'h94);
    tbl[11] = mk(0, 0, 8'h00, 8'h00, 1, 1, 8'h60, 8'hEE, 1, 1, 8'hC5, 8'h94);
    tbl[12] = mk(1, 0, 8'h60, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 8'hEE, 8'h94);
    // A not valid: its write must not land and must not stall B
    tbl[13] = mk(0, 1, 8'h70, 8'h00, 1, 0, 8'h70, 8'h00, 1, 1, 8'hEE, 8'hD5);
    tbl[14] = mk(1, 0, 8'h70, 8'h00, 0, 0, 8'h00, 8'h00, 1, 1, 8'hD5, 8'hD5);
  end

  initial begin
    idle();
    rstn = 1'b0;
    repeat (3) tick();
    check("rst_ready_a", bus.ready_a, 1'b0);
    check("rst_ready_b", bus.ready_b, 1'b0);
    check("rst_rd_a", bus.rd_data_a, 8'h00);
    check("rst_rd_b", bus.rd_data_b, 8'h00);

    // a write presented on the first post-reset edge must be ignored
    set_b(1'b1, 1'b1, 8'h00, 8'hFF);
    rstn = 1'b1;
    #1;
    check("first_edge_ready_a", bus.ready_a, 1'b0);
    check("first_edge_ready_b", bus.ready_b, 1'b0);
    tick();
    idle();
    #1;
    check("post_rst_ready_a", bus.ready_a, 1'b1);
    check("post_rst_ready_b", bus.ready_b, 1'b1);

    for (int i = 0; i < 256; i++) begin
      set_b(1'b1, 1'b0, 8'(i), 8'h00);
      tick();
      check("reset_read", bus.rd_data_b, 8'h00);
    end
    idle();

    for (int i = 0; i < 256; i++) begin
      set_a(1'b1, 1'b1, 8'(i), 8'(i) ^ 8'hA5);
      #1;
      check("fill_ready_a", bus.ready_a, 1'b1);
      tick();
      check("fill_rd_b_hold", bus.rd_data_b, 8'h00);
    end
    idle();
    for (int i = 0; i < 256; i++) begin
      set_b(1'b1, 1'b0, 8'(i), 8'h00);
      tick();
      check("readback", bus.rd_data_b, 8'(i) ^ 8'hA5);
    end
    idle();

    foreach (tbl[k]) begin
      set_a(tbl[k].va, tbl[k].opa, tbl[k].aa, tbl[k].da);
      set_b(tbl[k].vb, tbl[k].opb, tbl[k].ab, tbl[k].db);
      #1;
      check($sformatf("vec%0d_ready_a", k), bus.ready_a, tbl[k].rdy_a);
      check($sformatf("vec%0d_ready_b", k), bus.ready_b, tbl[k].rdy_b);
      tick();
      check($sformatf("vec%0d_rd_a", k), bus.rd_data_a, tbl[k].rd_a);
      check($sformatf("vec%0d_rd_b", k), bus.rd_data_b, tbl[k].rd_b);
    end
    idle();

    // read hold
    set_a(1'b1, 1'b1, 8'h08, 8'hC3);
    tick();
    idle();
    set_b(1'b1, 1'b0, 8'h08, 8'h00);
    tick();
    check("hold_read", bus.rd_data_b, 8'hC3);
    idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      check("hold_idle", bus.rd_data_b, 8'hC3);
    end
    set_b(1'b1, 1'b1, 8'h08, 8'h00);
    tick();
    idle();
    check("hold_after_write", bus.rd_data_b, 8'hC3);
    set_a(1'b1, 1'b0, 8'h08, 8'h00);
    tick();
    idle();
    check("hold_write_landed", bus.rd_data_a, 8'h00);
    check("hold_still", bus.rd_data_b, 8'hC3);

    // reset mid-stream
    set_a(1'b1, 1'b1, 8'h05, 8'h5A);
    tick();
    set_a(1'b1, 1'b0, 8'h05, 8'h00);
    tick();
    check("pre_rst_read", bus.rd_data_a, 8'h5A);
    set_a(1'b1, 1'b1, 8'h06, 8'h77);
    rstn = 1'b0;
    #1;
    check("mid_rst_ready_a", bus.ready_a, 1'b0);
    check("mid_rst_rd_a", bus.rd_data_a, 8'h00);
    tick();
    tick();
    idle();
    rstn = 1'b1;
    #1;
    check("rel_ready_a_low", bus.ready_a, 1'b0);
    tick();
    check("rel_ready_a_high", bus.ready_a, 1'b1);
    set_b(1'b1, 1'b0, 8'h05, 8'h00);
    set_a(1'b1, 1'b0, 8'h06, 8'h00);
    tick();
    check("mid_rst_cleared_05", bus.rd_data_b, 8'h00);
    check("mid_rst_cleared_06", bus.rd_data_a, 8'h00);
    idle();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/dual_port_mem.md
Name: dual_port_mem

Overview:
- Synchronous true dual-port memory, DEPTH = 2**ADDR_WIDTH words of DATA_WIDTH bits.
- Two independent request ports, A and B, each with a valid/ready handshake, an op select, an address, write data and registered read data.
- Serves two masters, e.g. a fill agent and a readback agent, sharing one storage array on one clock.
- A fixed A-over-B priority rule resolves same-address conflicts.

Parameters:
- ADDR_WIDTH, 8, address bits per port; DEPTH = 2**ADDR_WIDTH.
- DATA_WIDTH, 8, word width.

Ports:
- clk  in  1  single system clock, all logic on rising edge.
- rstn  in  1  reset; one clock; reset is asynchronous and active-low.
- valid_a  in  1  port A request valid.
- op_a  in  1  port A operation: 1 = write, 0 = read.
- addr_a  in  ADDR_WIDTH  port A word address.
- wr_data_a  in  DATA_WIDTH  port A write data.
- ready_a  out  1  port A can accept this cycle.
- rd_data_a  out  DATA_WIDTH  port A read data.
- valid_b, op_b, addr_b, wr_data_b, ready_b, rd_data_b: identical set for port B.

Behaviour:
- Acceptance: a port's request is accepted on a rising edge where valid_x && ready_x. Inputs are sampled only at acceptance. No other cycle has any effect.
- Reset (rstn = 0, asynchronous):
  - every memory word = 0.
  - rd_data_a = rd_data_b = 0.
  - ready_a = ready_b = 0.
  - internal ready-enable flop cleared.
- Post-reset: the ready-enable flop sets on the first rising edge with rstn = 1. ready outputs rise after that edge; no request is accepted on that first edge.
- ready_a = ready_en.
- ready_b = ready_en && !conflict.
  - conflict = valid_a && valid_b && addr_a == addr_b && (op_a || op_b).
  - ready_b is combinational from the port A/B inputs.
- Write (op = 1): mem[addr] <= wr_data on the accepting edge. rd_data of that port is unchanged.
- Read (op = 0): rd_data <= mem[addr] on the accepting edge, so it is visible one cycle after acceptance. rd_data holds until the next accepted read on that port or reset.
- Read returns the memory contents before any write accepted on the same edge.
  - Cross-port same-address read/write is prevented by the conflict stall.
  - Different addresses proceed fully in parallel.
- Both ports reading the same address: no conflict; both accepted; both get the same data.
- Conflict case: port A is served. Port B sees ready_b = 0 and must hold valid_b and its payload until accepted. Port B is accepted on a later cycle when the conflict clears.
- Reset asserted mid-transfer: the in-flight accepted op is lost and its write is not guaranteed to land. Memory is cleared. Masters reissue after ready returns.
- Address range is full 2**ADDR_WIDTH; no out-of-range case exists. Addresses do not auto-increment.
- Idle ports (valid = 0) hold all outputs.

Decomposition:
- Package dual_port_mem_pkg:
  - OP_READ = 1'b0 and OP_WRITE = 1'b1 as an op_e enum.
  - default ADDR_WIDTH / DATA_WIDTH localparams.
- Sub-module dual_port_mem_port, instantiated twice:
  - inputs: handshake qualification, stall input and the read-data register.
  - outputs: write-enable, address and data to the array.
- The top level holds the memory array, the ready-enable flop and the conflict logic.

Test Plan:
- Reset check: after reset, read all 256 addresses via port B. Every rd_data_b = 0x00. ready_a/ready_b = 0 while rstn = 0.
- Fill and read back: port A writes addr i with data i^0xA5 for i = 0..255. Port B then reads 0..255. Each rd_data_b = i^0xA5, one cycle after acceptance.
- Parallel different addresses: same cycle, A writes 0x10 = 0x3C and B reads 0x20 (previously 0x77). Both ready = 1. rd_data_b = 0x77. The next read of 0x10 gives 0x3C.
- Conflict: same cycle, A writes 0x40 = 0x99 and B reads 0x40 (old 0x11).
  - ready_b = 0 that cycle; A is accepted.
  - B is accepted the next cycle and returns 0x99.
  - Two simultaneous writes to 0x41: A's data is stored first, then B's; final value = B's data.
- Reset mid-operation: write 0x5A to 0x05, pulse rstn low for 2 cycles mid-stream. Then read 0x05 → 0x00. ready returns one edge after rstn deasserts.
- Read hold: read 0x08 = 0xC3, then idle 10 cycles, then write port B 0x08 = 0x00. rd_data_b stays 0xC3 throughout.
